pipe_hazard_unit: RTL

//  Parametrised hazard/forwarding controller for the 5-stage pipeline (IF/ID/EX/MEM/WB), sitting beside the ID-stage decoder.

---
 rtl/pipe_hazard_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller for the 5-stage pipeline: forward selects, load-use stalls, branch flushes.
// Optional perf counters are built when PIPE_HAZ_PERF_EN is defined.
module pipe_hazard_unit #(
    parameter int REG_AW    = 5,
    parameter int LOAD_LAT  = 1,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              ex_wreg,
    input  logic              ex_m2reg,
    input  logic [REG_AW-1:0] ex_wn,
    input  logic              mem_wreg,
    input  logic [REG_AW-1:0] mem_wn,
    input  logic              ex_br_taken,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              wpc,
    output logic              wir,
    output logic              id_bubble,
    output logic              if_flush
`ifdef PIPE_HAZ_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    localparam int MAXC = (LOAD_LAT > FLUSH_CYC) ? LOAD_LAT : FLUSH_CYC;
    localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC);

    localparam logic [CW-1:0] LD_INIT = CW'(LOAD_LAT - 1);
    localparam logic [CW-1:0] FL_INIT = CW'(FLUSH_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;

    logic rs_nz;
    logic rt_nz;
    logic lu;

    assign rs_nz = |id_rs;
    assign rt_nz = |id_rt;

    always_comb begin
        fwd_a = 2'b00;
        if (!id_use_rs)
            fwd_a = 2'b01;
        else if (ex_wreg && ex_wn == id_rs && rs_nz)
            fwd_a = 2'b10;
        else if (mem_wreg && mem_wn == id_rs && rs_nz)
            fwd_a = 2'b11;
    end

    always_comb begin
        fwd_b = 2'b00;
        if (!id_use_rt)
            fwd_b = 2'b01;
        else if (ex_wreg && ex_wn == id_rt && rt_nz)
            fwd_b = 2'b10;
        else if (mem_wreg && mem_wn == id_rt && rt_nz)
            fwd_b = 2'b11;
    end

    assign lu = ex_m2reg & (|ex_wn) &
                ((id_use_rs & (ex_wn == id_rs)) |
                 (id_use_rt & (ex_wn == id_rt)));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // A taken branch squashes the stalled instruction, so it preempts STALL.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            RUN, STALL: begin
                if (ex_br_taken) begin
                    if (FLUSH_CYC > 1) begin
                        state_nx = FLUSH;
                        cnt_nx   = FL_INIT;
                    end else begin
                        state_nx = RUN;
                        cnt_nx   = '0;
                    end
                end else if (state == STALL) begin
                    cnt_nx = cnt - CNT_ONE;
                    if (cnt == CNT_ONE)
                        state_nx = RUN;
                end else if (lu && LOAD_LAT > 1) begin
                    state_nx = STALL;
                    cnt_nx   = LD_INIT;
                end
            end
            FLUSH: begin
                cnt_nx = cnt - CNT_ONE;
                if (cnt == CNT_ONE)
                    state_nx = RUN;
            end
            default: begin
                state_nx = RUN;
                cnt_nx   = '0;
            end
        endcase
    end

    always_comb begin
        wpc       = 1'b1;
        wir       = 1'b1;
        id_bubble = 1'b0;
        if_flush  = 1'b0;
        unique case (state)
            RUN, STALL: begin
                if (ex_br_taken) begin
                    if_flush  = 1'b1;
                    id_bubble = 1'b1;
                end else if (state == STALL || lu) begin
                    wpc       = 1'b0;
                    wir       = 1'b0;
                    id_bubble = 1'b1;
                end
            end
            FLUSH: begin
                if_flush  = 1'b1;
                id_bubble = 1'b1;
            end
            default: begin
                wpc = 1'b1;
            end
        endcase
    end

`ifdef PIPE_HAZ_PERF_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!wpc && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (if_flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule
